// File: rtl/bar_pkg.sv
// bar_pkg: shared slot-state encoding and default sizing for the barrier tracker
package bar_pkg;
   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_FULL} slot_state_e;
   localparam int DEF_NUM_BLOCKS = 4;
   localparam int DEF_MAX_WARPS  = 8;
endpackage

// File: rtl/barrier_slot.sv
// barrier_slot: per-block warp arrival counter; FULL once every warp has reached the barrier
module barrier_slot import bar_pkg::*; #(
   parameter int WCNT_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cfg_hit,
   input  logic [WCNT_DEPTH-1:0] cfg_warps_i,
   input  logic                  arrive_hit,
   input  logic                  release_hit,
   output logic                  collect_o,
   output logic                  full_o,
   output logic                  err_o
);
   slot_state_e           state_q;
   logic [WCNT_DEPTH-1:0] count_q, target_q, count_d;
   assign count_d   = count_q + WCNT_DEPTH'(1);
   assign collect_o = state_q == S_COLLECT;
   assign full_o    = state_q == S_FULL;
   // Releasing a non-FULL slot, or arriving at an unconfigured slot, is a protocol error;
   // an arrival refused only because of a same-cycle configure is a retry, not an error.
   assign err_o     = (release_hit && state_q != S_FULL) || (arrive_hit && state_q == S_IDLE && !cfg_hit);
   // Configure beats release, release beats arrival; an arrival is only counted while collecting.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q  <= S_IDLE;
         count_q  <= '0;
         target_q <= '0;
      end else if (cfg_hit) begin
         state_q <= (cfg_warps_i != '0) ? S_COLLECT : S_IDLE;
         count_q <= '0;
         if (cfg_warps_i != '0) target_q <= cfg_warps_i;
      end else if (release_hit && state_q == S_FULL) begin
         state_q <= S_COLLECT;
         count_q <= '0;
      end else if (arrive_hit && state_q == S_COLLECT) begin
         state_q <= (count_d == target_q) ? S_FULL : S_COLLECT;
         count_q <= (count_d == target_q) ? '0 : count_d;
      end
endmodule

// File: rtl/barrier_tracker.sv
// barrier_tracker: tracks barrier arrivals for every resident block of a multiprocessor
module barrier_tracker import bar_pkg::*; #(
   parameter  int NUM_BLOCKS    = DEF_NUM_BLOCKS,
   parameter  int MAX_WARPS     = DEF_MAX_WARPS,
   localparam int BLOCKID_DEPTH = $clog2(NUM_BLOCKS),
   localparam int WCNT_DEPTH    = $clog2(MAX_WARPS + 1)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cfg_valid,
   input  logic [BLOCKID_DEPTH-1:0] cfg_block,
   input  logic [WCNT_DEPTH-1:0]    cfg_warps,
   input  logic                     arrive_valid,
   input  logic [BLOCKID_DEPTH-1:0] arrive_block,
   output logic                     arrive_ready,
   input  logic                     release_valid,
   input  logic [BLOCKID_DEPTH-1:0] release_block,
   output logic [NUM_BLOCKS-1:0]    bar_max,
   output logic                     err
);
   logic [NUM_BLOCKS-1:0] cfg_hit, arrive_hit, release_hit, collect, slot_err;
   logic                  err_q;
   for (genvar g = 0; g < NUM_BLOCKS; g++) begin : g_slot
      assign cfg_hit[g]     = cfg_valid && cfg_block == BLOCKID_DEPTH'(g);
      assign arrive_hit[g]  = arrive_valid && arrive_block == BLOCKID_DEPTH'(g);
      assign release_hit[g] = release_valid && release_block == BLOCKID_DEPTH'(g);
      barrier_slot #(.WCNT_DEPTH(WCNT_DEPTH)) u_slot (
         .clk         (clk),
         .rst_n       (rst_n),
         .cfg_hit     (cfg_hit[g]),
         .cfg_warps_i (cfg_warps),
         .arrive_hit  (arrive_hit[g]),
         .release_hit (release_hit[g]),
         .collect_o   (collect[g]),
         .full_o      (bar_max[g]),
         .err_o       (slot_err[g])
      );
   end
   assign arrive_ready = collect[arrive_block] && !cfg_hit[arrive_block];
   assign err          = err_q;
   // Any slot reporting a protocol error yields a one-cycle err pulse.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= |slot_err;
endmodule

// File: tb/tb_barrier_tracker.sv
// tb_barrier_tracker: directed self-checking bench for barrier_tracker
module tb_barrier_tracker;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cfg_valid = 1'b0;
   logic [1:0] cfg_block = '0;
   logic [3:0] cfg_warps = '0;
   logic       arrive_valid = 1'b0;
   logic [1:0] arrive_block = '0;
   logic       arrive_ready;
   logic       release_valid = 1'b0;
   logic [1:0] release_block = '0;
   logic [3:0] bar_max;
   logic       err;
   int n_chk = 0;
   int n_fail = 0;

   barrier_tracker dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cfg_valid     (cfg_valid),
      .cfg_block     (cfg_block),
      .cfg_warps     (cfg_warps),
      .arrive_valid  (arrive_valid),
      .arrive_block  (arrive_block),
      .arrive_ready  (arrive_ready),
      .release_valid (release_valid),
      .release_block (release_block),
      .bar_max       (bar_max),
      .err           (err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      cfg_valid = 1'b0;
      arrive_valid = 1'b0;
      release_valid = 1'b0;
   endtask

   task automatic cfg(input logic [1:0] b, input logic [3:0] w);
      cfg_valid = 1'b1;
      cfg_block = b;
      cfg_warps = w;
      tick();
      clr();
   endtask

   task automatic arrive(input logic [1:0] b);
      arrive_valid = 1'b1;
      arrive_block = b;
      tick();
      clr();
   endtask

   task automatic test_reset();
      arrive_block = 2'd2;
      tick();
      tick();
      n_chk++; if (bar_max !== 4'b0000) begin n_fail++; $display("FAIL reset_bar_max got %b want 0000", bar_max); end
      n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
      n_chk++; if (arrive_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", arrive_ready); end
      rst_n = 1'b1;
      tick();
      n_chk++; if (bar_max !== 4'b0000) begin n_fail++; $display("FAIL post_reset_bar_max got %b want 0000", bar_max); end
   endtask

   task automatic test_fill();
      cfg(2'd2, 4'd3);
      arrive_block = 2'd2;
      #1;
      n_chk++; if (arrive_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready got %b want 1", arrive_ready); end
      for (int i = 0; i < 3; i++) begin
         arrive(2'd2);
         n_chk++;
         if (bar_max !== ((i == 2) ? 4'b0100 : 4'b0000)) begin
            n_fail++;
            $display("FAIL fill_bar_max arrival %0d got %b want %b", i, bar_max, (i == 2) ? 4'b0100 : 4'b0000);
         end
      end
      #1;
      n_chk++; if (arrive_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready_full got %b want 0", arrive_ready); end
      n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL fill_err got %b want 0", err); end
   endtask

   task automatic test_full_hold();
      arrive_valid = 1'b1;
      arrive_block = 2'd2;
      #1;
      n_chk++; if (arrive_ready !== 1'b0) begin n_fail++; $display("FAIL hold_ready got %b want 0", arrive_ready); end
      tick();
      clr();
      n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL hold_err got %b want 0", err); end
      n_chk++; if (bar_max !== 4'b0100) begin n_fail++; $display("FAIL hold_bar_max got %b want 0100", bar_max); end
      release_valid = 1'b1;
      release_block = 2'd2;
      tick();
      clr();
      #1;
      n_chk++; if (bar_max !== 4'b0000) begin n_fail++; $display("FAIL release_bar_max got %b want 0000", bar_max); end
      n_chk++; if (arrive_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready got %b want 1", arrive_ready); end
      n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL release_err got %b want 0", err); end
   endtask

   task automatic test_concurrent();
      cfg(2'd0, 4'd1);
      cfg(2'd1, 4'd2);
      arrive_valid = 1'b1;
      arrive_block = 2'd0;
      release_valid = 1'b1;
      release_block = 2'd3;
      tick();
      clr();
      n_chk++; if (bar_max !== 4'b0001) begin n_fail++; $display("FAIL conc_bar_max got %b want 0001", bar_max); end
      n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL conc_err got %b want 1", err); end
      tick();
      n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL conc_err_pulse got %b want 0", err); end
   endtask

   task automatic test_async_reset();
      arrive(2'd1);
      n_chk++; if (bar_max !== 4'b0001) begin n_fail++; $display("FAIL partial_bar_max got %b want 0001", bar_max); end
      arrive_block = 2'd1;
      #2;
      rst_n = 1'b0;
      #1;
      n_chk++; if (bar_max !== 4'b0000) begin n_fail++; $display("FAIL async_bar_max got %b want 0000", bar_max); end
      n_chk++; if (arrive_ready !== 1'b0) begin n_fail++; $display("FAIL async_ready got %b want 0", arrive_ready); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      arrive_valid = 1'b1;
      arrive_block = 2'd1;
      #1;
      n_chk++; if (arrive_ready !== 1'b0) begin n_fail++; $display("FAIL idle_ready got %b want 0", arrive_ready); end
      tick();
      clr();
      n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL idle_err got %b want 1", err); end
      n_chk++; if (bar_max !== 4'b0000) begin n_fail++; $display("FAIL idle_bar_max got %b want 0000", bar_max); end
      tick();
      n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL idle_err_pulse got %b want 0", err); end
   endtask

   task automatic test_cfg_release();
      cfg(2'd3, 4'd1);
      arrive(2'd3);
      n_chk++; if (bar_max !== 4'b1000) begin n_fail++; $display("FAIL t1_bar_max got %b want 1000", bar_max); end
      cfg_valid = 1'b1;
      cfg_block = 2'd3;
      cfg_warps = 4'd4;
      release_valid = 1'b1;
      release_block = 2'd3;
      tick();
      clr();
      arrive_block = 2'd3;
      #1;
      n_chk++; if (bar_max !== 4'b0000) begin n_fail++; $display("FAIL cfgrel_bar_max got %b want 0000", bar_max); end
      n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL cfgrel_err got %b want 0", err); end
      n_chk++; if (arrive_ready !== 1'b1) begin n_fail++; $display("FAIL cfgrel_ready got %b want 1", arrive_ready); end
      for (int i = 0; i < 4; i++) begin
         arrive(2'd3);
         n_chk++;
         if (bar_max !== ((i == 3) ? 4'b1000 : 4'b0000)) begin
            n_fail++;
            $display("FAIL cfgrel_target arrival %0d got %b want %b", i, bar_max, (i == 3) ? 4'b1000 : 4'b0000);
         end
      end
   endtask

   task automatic test_collision();
      cfg(2'd3, 4'd2);
      cfg_valid = 1'b1;
      cfg_block = 2'd3;
      cfg_warps = 4'd2;
      arrive_valid = 1'b1;
      arrive_block = 2'd3;
      #1;
      n_chk++; if (arrive_ready !== 1'b0) begin n_fail++; $display("FAIL coll_ready got %b want 0", arrive_ready); end
      tick();
      clr();
      n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL coll_err got %b want 0", err); end
      arrive(2'd3);
      n_chk++; if (bar_max !== 4'b0000) begin n_fail++; $display("FAIL coll_count got %b want 0000", bar_max); end
      cfg(2'd3, 4'd0);
      arrive_block = 2'd3;
      #1;
      n_chk++; if (arrive_ready !== 1'b0) begin n_fail++; $display("FAIL zero_ready got %b want 0", arrive_ready); end
      arrive(2'd3);
      n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL zero_err got %b want 1", err); end
      n_chk++; if (bar_max !== 4'b0000) begin n_fail++; $display("FAIL zero_bar_max got %b want 0000", bar_max); end
   endtask

   task automatic test_back_to_back();
      cfg(2'd0, 4'd1);
      cfg(2'd1, 4'd1);
      arrive(2'd0);
      arrive_valid = 1'b1;
      arrive_block = 2'd1;
      release_valid = 1'b1;
      release_block = 2'd0;
      tick();
      clr();
      n_chk++; if (bar_max !== 4'b0010) begin n_fail++; $display("FAIL b2b_bar_max got %b want 0010", bar_max); end
      n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL b2b_err got %b want 0", err); end
      arrive(2'd0);
      n_chk++; if (bar_max !== 4'b0011) begin n_fail++; $display("FAIL b2b_both got %b want 0011", bar_max); end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_full_hold();
      test_concurrent();
      test_async_reset();
      test_cfg_release();
      test_collision();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
